// File: rtl/ysyx_22041461_ifetch_rsp.sv
// Single-outstanding instruction fetch: response valid LATENCY+1 cycles after accept, held until rsp_ready_i.
// Macro YSYX_22041461_IFETCH_ALIGN_CHK_EN enables misaligned-pc error responses that bypass memory.
module ysyx_22041461_ifetch_rsp #(
  parameter int unsigned LATENCY  = 2,
  parameter logic [31:0] RST_INST = 32'h00000013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [63:0] req_pc_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_inst_o,
  output logic        rsp_err_o,
  output logic        mem_en_o,
  output logic [63:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] inst_q, inst_d;

`ifdef YSYX_22041461_IFETCH_ALIGN_CHK_EN
  logic        err_q, err_d;
  logic        misaligned;

  assign misaligned = (req_pc_i[1:0] != 2'b00);
`else
  logic        unused_pc_lo;
  logic        unused_rst_inst;

  assign unused_pc_lo    = ^req_pc_i[1:0];
  assign unused_rst_inst = ^RST_INST;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    inst_d      = inst_q;
`ifdef YSYX_22041461_IFETCH_ALIGN_CHK_EN
    err_d       = err_q;
`endif
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    mem_en_o    = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          addr_d = {req_pc_i[63:2], 2'b00};
`ifdef YSYX_22041461_IFETCH_ALIGN_CHK_EN
          // Misaligned fetches never reach memory; answer with a nop and the fault flag.
          if (misaligned) begin
            inst_d  = RST_INST;
            err_d   = 1'b1;
            cnt_d   = 4'd0;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
`else
          cnt_d   = CNT_INIT;
          state_d = WAIT;
`endif
        end
      end

      WAIT: begin
        mem_en_o = 1'b1;
        // Leave on 1 (or a stray 0) so the counter can never wrap.
        if (cnt_q <= 4'd1) begin
          inst_d  = mem_rdata_i;
          cnt_d   = 4'd0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 64'd0;
      inst_q  <= 32'd0;
`ifdef YSYX_22041461_IFETCH_ALIGN_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
`ifdef YSYX_22041461_IFETCH_ALIGN_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign mem_addr_o = addr_q;
  assign rsp_inst_o = inst_q;

`ifdef YSYX_22041461_IFETCH_ALIGN_CHK_EN
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041461_ifetch_rsp.sv
// Bench for ysyx_22041461_ifetch_rsp: directed scenarios then random traffic against a transaction-level model.
module tb_ysyx_22041461_ifetch_rsp;

  localparam int unsigned LAT      = 2;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic        rsp_err;
  logic        mem_en;
  logic [63:0] mem_addr;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ysyx_22041461_ifetch_rsp #(
    .LATENCY (LAT),
    .RST_INST(NOP_INST)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_pc_i   (req_pc),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_inst_o (rsp_inst),
    .rsp_err_o  (rsp_err),
    .mem_en_o   (mem_en),
    .mem_addr_o (mem_addr),
    .mem_rdata_i(mem_rdata)
  );

  // Backing memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0000_0000_8000_0000) return 32'h00100093;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0000;
  endfunction

  assign mem_rdata = mem_en ? mem_word(mem_addr) : 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one transaction at a time, response due at a computed cycle.
  int          cyc      = 0;
  bit          en       = 0;
  bit          busy     = 0;
  bit          post_rst = 0;
  int          rsp_at   = 0;
  int          acc_cnt  = 0;
  logic [63:0] exp_addr = 64'd0;
  logic [63:0] last_addr = 64'd0;
  logic [31:0] exp_inst = 32'd0;
  logic        exp_err  = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (en) begin
      if (!busy) begin
        check("idle_req_ready", req_ready, 1);
        check("idle_rsp_valid", rsp_valid, 0);
        check("idle_mem_en", mem_en, 0);
        check("idle_mem_addr", mem_addr, last_addr);
        if (post_rst) begin
          check("rst_rsp_inst", rsp_inst, 0);
          check("rst_rsp_err", rsp_err, 0);
          check("rst_mem_addr", mem_addr, 0);
        end
      end else if (cyc < rsp_at) begin
        check("wait_mem_en", mem_en, 1);
        check("wait_mem_addr", mem_addr, exp_addr);
        check("wait_req_ready", req_ready, 0);
        check("wait_rsp_valid", rsp_valid, 0);
      end else begin
        check("resp_rsp_valid", rsp_valid, 1);
        check("resp_rsp_inst", rsp_inst, exp_inst);
        check("resp_rsp_err", rsp_err, exp_err);
        check("resp_mem_en", mem_en, 0);
        check("resp_req_ready", req_ready, 0);
        check("resp_mem_addr", mem_addr, exp_addr);
      end
    end

    // Outcome of the coming clock edge.
    if (rst) begin
      busy      = 0;
      last_addr = 64'd0;
      post_rst  = 1;
      en        = 1;
    end else if (en) begin
      if (!busy && req_valid) begin
        busy      = 1;
        post_rst  = 0;
        acc_cnt++;
        exp_addr  = {req_pc[63:2], 2'b00};
        last_addr = exp_addr;
`ifdef YSYX_22041461_IFETCH_ALIGN_CHK_EN
        if (req_pc[1:0] != 2'b00) begin
          rsp_at   = cyc + 1;
          exp_inst = NOP_INST;
          exp_err  = 1'b1;
        end else begin
          rsp_at   = cyc + LAT + 1;
          exp_inst = mem_word(exp_addr);
          exp_err  = 1'b0;
        end
`else
        rsp_at   = cyc + LAT + 1;
        exp_inst = mem_word(exp_addr);
        exp_err  = 1'b0;
`endif
      end else if (busy && cyc >= rsp_at && rsp_ready) begin
        busy     = 0;
        post_rst = 0;
      end
    end
  end

  task automatic drive(input logic r, input logic v, input logic [63:0] pc, input logic rr);
    @(posedge clk);
    #1;
    rst       = r;
    req_valid = v;
    req_pc    = pc;
    rsp_ready = rr;
  endtask

  initial begin
    int base;
    int idx;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_pc    = 64'd0;
    rsp_ready = 1'b0;
    repeat (3) drive(1, 0, 64'd0, 0);

    // First fetch, then response held against rsp_ready low.
    drive(0, 1, 64'h0000_0000_8000_0000, 0);
    repeat (8) drive(0, 0, 64'd0, 0);
    repeat (2) drive(0, 0, 64'd0, 1);

    // Back-to-back sequential fetches with rsp_ready held high.
    base = acc_cnt;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      idx       = acc_cnt - base;
      rst       = 1'b0;
      req_valid = (idx < 3);
      req_pc    = 64'h0000_0000_8000_0000 + 64'(4 * idx);
      rsp_ready = 1'b1;
    end
    repeat (3) drive(0, 0, 64'd0, 1);

    // Reset during the second wait cycle drops the fetch.
    drive(0, 1, 64'h0000_0000_8000_000C, 1);
    drive(0, 0, 64'd0, 1);
    drive(1, 0, 64'd0, 1);
    repeat (2) drive(0, 0, 64'd0, 1);
    drive(0, 1, 64'h0000_0000_8000_0010, 1);
    repeat (6) drive(0, 0, 64'd0, 1);

    // New pc offered while busy must be ignored.
    drive(0, 1, 64'h0000_0000_8000_0020, 1);
    drive(0, 1, 64'h0000_0000_8000_0444, 1);
    drive(0, 0, 64'h0000_0000_8000_0888, 1);
    drive(0, 1, 64'h0000_0000_8000_0888, 0);
    repeat (6) drive(0, 0, 64'd0, 1);

    // Misaligned pc.
    drive(0, 1, 64'h0000_0000_8000_0002, 1);
    repeat (6) drive(0, 0, 64'd0, 1);

    // Random traffic with occasional resets and backpressure.
    for (int k = 0; k < 3000; k++) begin
      drive(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 9) < 7),
            {$urandom, $urandom},
            ($urandom_range(0, 9) < 6));
    end
    repeat (3) drive(0, 0, 64'd0, 1);

    @(posedge clk);
    if (acc_cnt < 20) check("accept_count_low", acc_cnt, 20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22041461_ifetch_rsp.md
YSYX_22041461_IFETCH_RSP -- requirements
Module: ysyx_22041461_IFETCH_RSP

Interface
REQ-001: Parameter LATENCY, default 2, memory wait-state cycles per fetch; legal range 1..15.
REQ-002: Parameter RST_INST, default 32'h00000013, instruction value returned on error (nop).
REQ-003: clk  input  1  single clock; all logic on rising edge.
REQ-004: rst  input  1  reset, synchronous, active-high.
REQ-005: req_valid  input  1  CPU presents a fetch request.
REQ-006: req_ready  output  1  block accepts a request this cycle.
REQ-007: req_pc  input  64  fetch address from the CPU pc.
REQ-008: rsp_valid  output  1  rsp_inst/rsp_err are valid.
REQ-009: rsp_ready  input  1  CPU consumes the response.
REQ-010: rsp_inst  output  32  fetched instruction.
REQ-011: rsp_err  output  1  fetch fault flag.
REQ-012: mem_en  output  1  backing-memory read enable.
REQ-013: mem_addr  output  64  word-aligned read address.
REQ-014: mem_rdata  input  32  read data, combinationally valid while mem_en=1.

Function
REQ-015: FSM states SHALL be IDLE, WAIT, RESP; exactly one request outstanding.
REQ-016: req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESP.
REQ-017: IDLE with req_valid=1 SHALL capture {req_pc[63:2],2'b00} into the address register, load wait counter with LATENCY, go to WAIT.
REQ-018: In WAIT, mem_en SHALL be 1, mem_addr SHALL equal the captured address, counter SHALL decrement each cycle.
REQ-019: In the WAIT cycle where counter equals 1, mem_rdata SHALL be registered into rsp_inst and FSM SHALL go to RESP.
REQ-020: Request accepted at edge T SHALL yield rsp_valid=1 from cycle T+LATENCY+1; mem_en SHALL be 0 outside WAIT, mem_addr held.
REQ-021: In RESP, rsp_inst and rsp_err SHALL hold stable until rsp_valid&&rsp_ready; then FSM SHALL go to IDLE.
REQ-022: req_valid during WAIT/RESP SHALL be ignored (not captured); CPU holds req_pc until req_ready.
REQ-023: Minimum back-to-back throughput SHALL be one fetch per LATENCY+2 cycles (rsp_ready held 1).
REQ-024: Counter SHALL be 4 bits and never wrap below 1 in WAIT.

Reset
REQ-025: rst=1 at any edge SHALL force IDLE, rsp_inst=0, rsp_err=0, counter=0, address register=0, regardless of state.
REQ-026: Reset mid-WAIT or mid-RESP SHALL drop the transaction with no response; req_ready=1 on the first cycle after rst deasserts.
REQ-027: rst SHALL take priority over every simultaneous handshake.

Configuration
REQ-028: Macro YSYX_22041461_IFETCH_ALIGN_CHK_EN SHALL gate misalignment checking.
REQ-029: Defined: accepted req_pc[1:0]!=0 SHALL skip WAIT (mem_en stays 0), go to RESP next cycle with rsp_inst=RST_INST, rsp_err=1.
REQ-030: Undefined: req_pc[1:0] SHALL be ignored, aligned fetch performed normally, rsp_err tied to 0.

Verification
REQ-031: LATENCY=2, req_pc=0x80000000 accepted cycle 0, mem_rdata=0x00100093 -> mem_en=1 cycles 1-2, rsp_valid=1 cycle 3, rsp_inst=0x00100093, rsp_err=0.
REQ-032: rsp_ready held 0 for 5 cycles in RESP -> rsp_inst/rsp_valid stable; rsp_ready=1 -> IDLE, req_ready=1 next cycle.
REQ-033: Continuous req_valid, rsp_ready=1, pcs 0x80000000/04/08 -> responses every 4 cycles, in order, correct mem_addr each.
REQ-034: rst=1 in second WAIT cycle -> no rsp_valid ever for that request; next request at 0x80000010 completes normally.
REQ-035: Macro defined, req_pc=0x80000002 -> mem_en never 1, rsp_valid next cycle, rsp_inst=0x00000013, rsp_err=1; macro undefined -> mem_addr=0x80000000, rsp_err=0.
REQ-036: req_valid toggled during WAIT with new pc -> ignored; response carries the originally captured address data.
